bram_image_loader: RTL and testbench
====================================

# bram_image_loader

Writer side of the 784-byte image BRAM that the CNN pipeline reads from address 0 upward. A byte stream from the UART receiver arrives as `rx_data`/`rx_valid`, framed by a sync byte. The block writes the frame into BRAM port A and holds the CNN pipeline in reset while loading. When the frame is complete, it releases the CNN reset so the pipeline re-reads the new image from address 0.

## Interface
- `NUM_PIXELS`, 784, bytes per frame; one BRAM word per byte.
- `ADDR_BIT`, 10, BRAM address width.
- `SYNC_BYTE`, 8'hAA, frame start marker; recognised only in IDLE.
- `TIMEOUT_CYCLES`, 1_000_000, maximum inter-byte gap in LOAD before abort.
- `TO_BIT`, 20, timeout counter width; must satisfy 2^TO_BIT > TIMEOUT_CYCLES.
- `CNN_RST_CYCLES`, 4, cycles `cnn_rst_n` stays low after the last write.

Ports:
- `clk`  in  1  single clock for everything.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte; valid only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per received byte; no backpressure.
- `wea`  out  1  BRAM write enable, one cycle per byte.
- `addra`  out  ADDR_BIT  BRAM write address.
- `dina`  out  8  BRAM write data.
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse when `cnn_rst_n` rises.
- `timeout_err`  out  1  sticky abort flag; cleared on the next accepted sync byte.
- `cnn_rst_n`  out  1  active-low reset to the CNN top; low while a frame is in flight.

## Operation
- Registers: state, `pix_cnt` (ADDR_BIT), `to_cnt` (TO_BIT), `rel_cnt` (3 bits minimum).
- States: IDLE, LOAD, RELEASE.
- **Reset values:** state=RELEASE, `rel_cnt`=0, `wea`=0, `addra`=0, `dina`=0, `busy`=1, `frame_done`=0, `timeout_err`=0, `cnn_rst_n`=0.
- Because reset enters RELEASE, the BRAM init image is classified once after reset.
- **IDLE:**
  - `rx_valid` with `rx_data`==SYNC_BYTE: go to LOAD, `pix_cnt`=0, `to_cnt`=0, `cnn_rst_n`=0, `timeout_err`=0.
  - All other bytes are dropped.
  - `cnn_rst_n` is left unchanged: high after a good frame, low after a timeout.
- **LOAD:**
  - On `rx_valid`: register `wea`=1, `addra`=`pix_cnt`, `dina`=`rx_data`; increment `pix_cnt`; clear `to_cnt`.
  - SYNC_BYTE in LOAD is pixel data, not a restart.
  - Byte accepted while `pix_cnt`==NUM_PIXELS-1: go to RELEASE, `rel_cnt`=0.
  - No `rx_valid`: `to_cnt` increments. If `to_cnt`==TIMEOUT_CYCLES-1: set `timeout_err`=1, go to IDLE, keep `cnn_rst_n`=0. A partial frame is never classified.
- **RELEASE:**
  - `rel_cnt` increments every cycle; all `rx_valid` strobes are dropped.
  - When `rel_cnt`==CNN_RST_CYCLES-1: `cnn_rst_n`=1, `frame_done`=1 for one cycle, go to IDLE.
- `addra` never exceeds NUM_PIXELS-1, and `pix_cnt` never wraps. Every frame is exactly NUM_PIXELS writes.
- `wea` is 0 in every cycle not immediately following an accepted LOAD byte. `addra`/`dina` hold their last values when `wea`=0.

## Timing
- Write latency: `rx_valid` in cycle n gives `wea`/`addra`/`dina` valid in cycle n+1.
- Back-to-back `rx_valid` (every cycle) is supported, giving one write per cycle.
- Last byte at cycle n:
  - Write occurs in cycle n+1; state is RELEASE from n+1.
  - `cnn_rst_n` is low through cycle n+CNN_RST_CYCLES.
  - `cnn_rst_n` is high and `frame_done`=1 in cycle n+CNN_RST_CYCLES+1.
- `cnn_rst_n` goes low in the cycle after the sync byte strobe. This is never later than the first pixel write, so the CNN address counter restarts at 0 after release.
- Timeout: last byte (or sync byte) at cycle n with no further `rx_valid` gives `timeout_err`=1 and state IDLE at cycle n+TIMEOUT_CYCLES.
- `rst` asserted at any time (mid-LOAD, mid-RELEASE): all outputs take reset values immediately, without waiting for a clock edge. A partially written frame remains in the BRAM but is overwritten only by the next full frame. After `rst` deasserts, the post-reset RELEASE runs (classifies BRAM content).

## Test plan
- **Post-reset:** release `rst`, send no bytes -> `cnn_rst_n` low for 4 cycles, then `cnn_rst_n`=1, `frame_done` pulses once, `busy`=0.
- **Full frame, back-to-back:** 8'hAA then bytes 0..783 mod 256, one per cycle -> 784 writes, `addra` 0..783 with `dina`=`addra`[7:0]. `cnn_rst_n` rises 4 cycles after the last byte strobe + 1, with one `frame_done`.
- **Sparse frame with embedded 8'hAA:** bytes spaced 10 cycles apart, pixel 5 = 8'hAA -> written at `addra`=5, no restart, 784 writes total.
- **Timeout:** TIMEOUT_CYCLES=100, send sync + 300 bytes, then silence -> at 100 cycles after the last byte, `timeout_err`=1, `busy`=0, `cnn_rst_n` stays 0, no `frame_done`. Then send a new sync -> `timeout_err` clears.
- **IDLE noise:** bytes 8'h00, 8'h55 in IDLE -> no writes, state unchanged. Bytes arriving during RELEASE -> dropped, no writes.
- **Async reset at pixel 400:** `rst` pulsed mid-cycle -> `wea`=0, `addra`=0, `cnn_rst_n`=0 without waiting for a clock edge. A following full frame loads correctly from address 0.

Source files
------------

// File: rtl/bram_image_loader.sv
// bram_image_loader: writes one sync-framed UART image into BRAM port A and
// holds the CNN pipeline in reset until a complete frame has been written.
module bram_image_loader #(
    parameter int         NUM_PIXELS     = 784,
    parameter int         ADDR_BIT       = 10,
    parameter logic [7:0] SYNC_BYTE      = 8'hAA,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter int         TO_BIT         = 20,
    parameter int         CNN_RST_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                wea,
    output logic [ADDR_BIT-1:0] addra,
    output logic [7:0]          dina,
    output logic                busy,
    output logic                frame_done,
    output logic                timeout_err,
    output logic                cnn_rst_n
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [ADDR_BIT-1:0] LAST_PIX = ADDR_BIT'(NUM_PIXELS - 1);
    localparam logic [TO_BIT-1:0]   TO_LAST  = TO_BIT'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]          REL_LAST = 3'(CNN_RST_CYCLES - 1);

    state_t              state_r, state_s;
    logic [ADDR_BIT-1:0] pix_cnt_r, pix_cnt_s;
    logic [TO_BIT-1:0]   to_cnt_r, to_cnt_s, to_inc_s;
    logic [2:0]          rel_cnt_r, rel_cnt_s;
    logic                wea_s;
    logic [ADDR_BIT-1:0] addra_s;
    logic [7:0]          dina_s;
    logic                frame_done_s;
    logic                timeout_err_s;
    logic                cnn_rst_n_s;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s       = state_r;
        pix_cnt_s     = pix_cnt_r;
        to_cnt_s      = to_cnt_r;
        rel_cnt_s     = rel_cnt_r;
        wea_s         = 1'b0;
        addra_s       = addra;
        dina_s        = dina;
        frame_done_s  = 1'b0;
        timeout_err_s = timeout_err;
        cnn_rst_n_s   = cnn_rst_n;
        // The timeout compares the post-increment count so that the abort is
        // visible exactly TIMEOUT_CYCLES cycles after the last accepted byte.
        to_inc_s      = to_cnt_r + TO_BIT'(1);

        case (state_r)
            IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_s       = LOAD;
                    pix_cnt_s     = '0;
                    to_cnt_s      = '0;
                    cnn_rst_n_s   = 1'b0;
                    timeout_err_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (rx_valid) begin
                    wea_s    = 1'b1;
                    addra_s  = pix_cnt_r;
                    dina_s   = rx_data;
                    to_cnt_s = '0;
                    if (pix_cnt_r == LAST_PIX) begin
                        // Counter parks on the last address instead of wrapping.
                        state_s   = RELEASE;
                        rel_cnt_s = 3'd0;
                    end else begin
                        pix_cnt_s = pix_cnt_r + ADDR_BIT'(1);
                    end
                end else if (to_inc_s == TO_LAST) begin
                    // Partial frame: abort and keep the CNN in reset.
                    timeout_err_s = 1'b1;
                    cnn_rst_n_s   = 1'b0;
                    state_s       = IDLE;
                end else begin
                    to_cnt_s = to_inc_s;
                end
            end
            RELEASE: begin
                if (rel_cnt_r == REL_LAST) begin
                    cnn_rst_n_s  = 1'b1;
                    frame_done_s = 1'b1;
                    state_s      = IDLE;
                end else begin
                    rel_cnt_s = rel_cnt_r + 3'd1;
                end
            end
            default: begin
                // Illegal encoding: recover through a full CNN reset cycle.
                state_s     = RELEASE;
                rel_cnt_s   = 3'd0;
                cnn_rst_n_s = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; reset enters RELEASE so the
    // BRAM init image is classified once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= RELEASE;
            pix_cnt_r   <= '0;
            to_cnt_r    <= '0;
            rel_cnt_r   <= 3'd0;
            wea         <= 1'b0;
            addra       <= '0;
            dina        <= 8'h00;
            busy        <= 1'b1;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            cnn_rst_n   <= 1'b0;
        end else begin
            state_r     <= state_s;
            pix_cnt_r   <= pix_cnt_s;
            to_cnt_r    <= to_cnt_s;
            rel_cnt_r   <= rel_cnt_s;
            wea         <= wea_s;
            addra       <= addra_s;
            dina        <= dina_s;
            busy        <= (state_s != IDLE);
            frame_done  <= frame_done_s;
            timeout_err <= timeout_err_s;
            cnn_rst_n   <= cnn_rst_n_s;
        end
    end

endmodule

// File: tb/tb_bram_image_loader.sv
// Directed bench for bram_image_loader with a write scoreboard.
module tb_bram_image_loader;

    localparam int NP = 784;
    localparam int AB = 10;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          wea;
    logic [AB-1:0] addra;
    logic [7:0]    dina;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;
    logic          cnn_rst_n;

    int tests = 0;
    int fails = 0;
    int wr_count = 0;
    int fd_count = 0;

    typedef struct packed {
        logic [AB-1:0] a;
        logic [7:0]    d;
    } wr_t;

    wr_t           sb[$];
    wr_t           mon_e;
    logic [AB-1:0] hold_a = '0;
    logic [7:0]    hold_d = 8'h00;

    always #5 clk = ~clk;

    bram_image_loader #(
        .NUM_PIXELS     (NP),
        .ADDR_BIT       (AB),
        .SYNC_BYTE      (8'hAA),
        .TIMEOUT_CYCLES (TO),
        .TO_BIT         (20),
        .CNN_RST_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .wea         (wea),
        .addra       (addra),
        .dina        (dina),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err),
        .cnn_rst_n   (cnn_rst_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every write must match the scoreboard head; between
    // writes addra/dina must hold the last written values.
    always @(negedge clk) begin
        if (rst) begin
            hold_a = '0;
            hold_d = 8'h00;
        end else begin
            if (frame_done) fd_count++;
            if (wea) begin
                wr_count++;
                check("wr_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("wr_addr", 32'(addra), 32'(mon_e.a));
                    check("wr_data", 32'(dina), 32'(mon_e.d));
                    hold_a = mon_e.a;
                    hold_d = mon_e.d;
                end
            end else begin
                check("hold_addr", 32'(addra), 32'(hold_a));
                check("hold_data", 32'(dina), 32'(hold_d));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] pix(input int i, input int salt);
        logic [7:0] v;
        v = 8'(i) ^ 8'(salt);
        if (salt != 0 && i == 5) v = 8'hAA;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sync(input string tag);
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check({tag, "_sync_cnn_low"}, 32'(cnn_rst_n), 32'd0);
        check({tag, "_sync_busy"}, 32'(busy), 32'd1);
        check({tag, "_sync_to_clr"}, 32'(timeout_err), 32'd0);
    endtask

    task automatic send_pixels(input int first, input int count, input int gap, input int salt);
        for (int i = first; i < first + count; i++) begin
            rx_data  = pix(i, salt);
            rx_valid = 1'b1;
            sb.push_back(wr_t'{a: AB'(i), d: pix(i, salt)});
            tick();
            rx_valid = 1'b0;
            if (i != first + count - 1) begin
                for (int g = 1; g < gap; g++) tick();
            end
        end
    endtask

    // Entered in the first RELEASE cycle (rel_cnt = 0); a sync byte arriving
    // during RELEASE must be dropped.
    task automatic release_check(input string tag);
        check({tag, "_r1_cnn"}, 32'(cnn_rst_n), 32'd0);
        check({tag, "_r1_busy"}, 32'(busy), 32'd1);
        check({tag, "_r1_fd"}, 32'(frame_done), 32'd0);
        tick();
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        check({tag, "_r2_cnn"}, 32'(cnn_rst_n), 32'd0);
        tick();
        rx_valid = 1'b0;
        check({tag, "_r3_cnn"}, 32'(cnn_rst_n), 32'd0);
        tick();
        check({tag, "_r4_cnn"}, 32'(cnn_rst_n), 32'd0);
        check({tag, "_r4_fd"}, 32'(frame_done), 32'd0);
        tick();
        check({tag, "_r5_cnn"}, 32'(cnn_rst_n), 32'd1);
        check({tag, "_r5_fd"}, 32'(frame_done), 32'd1);
        check({tag, "_r5_busy"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_r6_fd"}, 32'(frame_done), 32'd0);
        check({tag, "_r6_cnn"}, 32'(cnn_rst_n), 32'd1);
        check({tag, "_r6_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic full_frame(input string tag, input int gap, input int salt);
        int wr0;
        wr0 = wr_count;
        send_sync(tag);
        send_pixels(0, NP, gap, salt);
        release_check(tag);
        check({tag, "_writes"}, 32'(wr_count - wr0), 32'(NP));
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int fdc;
        int wr0;

        // Reset values
        tick();
        tick();
        check("rst_wea", 32'(wea), 32'd0);
        check("rst_addra", 32'(addra), 32'd0);
        check("rst_dina", 32'(dina), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_to", 32'(timeout_err), 32'd0);
        check("rst_cnn", 32'(cnn_rst_n), 32'd0);

        // Post-reset RELEASE
        rst = 1'b0;
        release_check("post_rst");

        // Back-to-back frame
        full_frame("b2b", 1, 0);

        // IDLE noise
        wr0 = wr_count;
        rx_data  = 8'h00;
        rx_valid = 1'b1;
        tick();
        rx_data = 8'h55;
        tick();
        rx_valid = 1'b0;
        tick();
        check("noise_busy", 32'(busy), 32'd0);
        check("noise_cnn", 32'(cnn_rst_n), 32'd1);
        check("noise_writes", 32'(wr_count - wr0), 32'd0);

        // Sparse frame with embedded sync value at pixel 5
        full_frame("sparse", 10, 8'h3C);

        // Timeout after 300 bytes
        send_sync("to");
        send_pixels(0, 300, 1, 3);
        repeat (TO - 2) tick();
        check("to_pre_err", 32'(timeout_err), 32'd0);
        check("to_pre_busy", 32'(busy), 32'd1);
        tick();
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_cnn", 32'(cnn_rst_n), 32'd0);
        fdc = fd_count;
        repeat (20) tick();
        check("to_no_fd", 32'(fd_count - fdc), 32'd0);
        check("to_cnn_hold", 32'(cnn_rst_n), 32'd0);
        check("to_err_sticky", 32'(timeout_err), 32'd1);
        full_frame("after_to", 1, 9);

        // Async reset at pixel 400
        send_sync("arst");
        send_pixels(0, 400, 1, 7);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_wea", 32'(wea), 32'd0);
        check("arst_addra", 32'(addra), 32'd0);
        check("arst_dina", 32'(dina), 32'd0);
        check("arst_cnn", 32'(cnn_rst_n), 32'd0);
        check("arst_busy", 32'(busy), 32'd1);
        check("arst_sb_empty", 32'(sb.size()), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        release_check("arst_rel");
        full_frame("final", 1, 0);

        check("fd_total", 32'(fd_count), 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
